// File: rtl/kernel_cc_pkg.sv
// Shared FSM encoding and beat-size constants for the kernel_cc write-back controller.
package kernel_cc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wb_state_t;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

   function automatic int unsigned bytes_per_beat(input int unsigned data_width);
      return data_width / 8;
   endfunction

   localparam int unsigned BYTES_PER_BEAT = DEFAULT_DATA_WIDTH / 8;

endpackage

// File: rtl/kernel_cc_write_back_ctrl_if.sv
// Valid/ready write-request channel between the controller and its write sink.
interface kernel_cc_write_back_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);

   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/kernel_cc_write_back_ctrl_outreg.sv
// Single-entry output register for the write channel; contents are frozen while the sink stalls.
module kernel_cc_write_back_ctrl_outreg #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   kernel_cc_write_back_ctrl_if.master wr
);

   // A load only happens when the slot is empty or draining this edge, so it always wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr.wr_valid <= 1'b0;
         wr.wr_addr  <= '0;
         wr.wr_data  <= '0;
      end else if (load) begin
         wr.wr_valid <= 1'b1;
         wr.wr_addr  <= load_addr;
         wr.wr_data  <= load_data;
      end else if (wr.wr_ready) begin
         wr.wr_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/kernel_cc_write_back_ctrl.sv
// Write-back controller: pops a job token, streams data words from a FIFO to a
// valid/ready write sink at consecutive byte addresses, then pulses done.
module kernel_cc_write_back_ctrl
   import kernel_cc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_empty_n,
   output logic                  start_read,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [CNT_WIDTH-1:0]  cfg_count,
   input  logic                  din_empty_n,
   output logic                  din_read,
   input  logic [DATA_WIDTH-1:0] din_dout,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  done,
   output logic                  idle
);

   localparam int unsigned BEAT_BYTES = bytes_per_beat(DATA_WIDTH);

   wb_state_t             state;
   wb_state_t             state_next;
   logic                  active;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [CNT_WIDTH-1:0]  beat_count;
   logic [CNT_WIDTH-1:0]  issued;
   logic [CNT_WIDTH-1:0]  accepted;
   logic                  handshake;
   logic                  last_accept;

   kernel_cc_write_back_ctrl_if #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) wr_bus ();

   assign wr_bus.wr_ready = wr_ready;
   assign wr_valid        = wr_bus.wr_valid;
   assign wr_addr         = wr_bus.wr_addr;
   assign wr_data         = wr_bus.wr_data;

   assign handshake   = wr_bus.wr_valid & wr_ready;
   assign last_accept = handshake && (accepted == beat_count - CNT_WIDTH'(1));

   // Holds off token pops until the first clock edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active <= 1'b0;
      end else begin
         active <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start_read) begin
               state_next = (cfg_count == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_accept) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // A data word is pulled only when the output slot is free or draining this cycle.
   always_comb begin
      start_read = 1'b0;
      din_read   = 1'b0;
      done       = 1'b0;
      idle       = 1'b0;
      case (state)
         ST_IDLE: begin
            idle       = 1'b1;
            start_read = active & start_empty_n;
         end
         ST_RUN: begin
            din_read = din_empty_n & (issued < beat_count) & (~wr_bus.wr_valid | wr_ready);
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_count <= '0;
         issued     <= '0;
         accepted   <= '0;
         next_addr  <= '0;
      end else if (start_read) begin
         beat_count <= cfg_count;
         issued     <= '0;
         accepted   <= '0;
         next_addr  <= cfg_base_addr;
      end else begin
         if (din_read) begin
            issued    <= issued + CNT_WIDTH'(1);
            next_addr <= next_addr + ADDR_WIDTH'(BEAT_BYTES);
         end
         if (handshake) begin
            accepted <= accepted + CNT_WIDTH'(1);
         end
      end
   end

   kernel_cc_write_back_ctrl_outreg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_outreg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (din_read),
      .load_addr (next_addr),
      .load_data (din_dout),
      .wr        (wr_bus.master)
   );

endmodule

// File: tb/tb_kernel_cc_write_back_ctrl.sv
// Self-checking bench: FIFO/sink models plus a job-level scoreboard of expected addresses and data.
module tb_kernel_cc_write_back_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start_empty_n;
   logic        start_read;
   logic [31:0] cfg_base_addr;
   logic [15:0] cfg_count;
   logic        din_empty_n;
   logic        din_read;
   logic [31:0] din_dout;
   logic        done;
   logic        idle;

   kernel_cc_write_back_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   kernel_cc_write_back_ctrl #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .CNT_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_empty_n (start_empty_n),
      .start_read    (start_read),
      .cfg_base_addr (cfg_base_addr),
      .cfg_count     (cfg_count),
      .din_empty_n   (din_empty_n),
      .din_read      (din_read),
      .din_dout      (din_dout),
      .wr_valid      (bus.wr_valid),
      .wr_ready      (bus.wr_ready),
      .wr_addr       (bus.wr_addr),
      .wr_data       (bus.wr_data),
      .done          (done),
      .idle          (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] tok_base[$];
   logic [15:0] tok_cnt[$];
   logic [31:0] data_q[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          pend_done[$];

   int cyc = 0;
   int accepted_total = 0;
   int cum_target = 0;
   int job_beats = 0;
   int pop_cyc = 0;
   int done_cyc = 0;
   int pop_gap = 0;
   int first_beat_cyc = -1;
   int last_beat_cyc = 0;
   int din_reads = 0;
   int valid_cycles = 0;
   int pops = 0;
   int done_count = 0;
   int ready_pct = 100;
   int din_gap_pct = 0;
   int stall_left = 0;
   logic        hold_pending = 1'b0;
   logic [31:0] held_addr;
   logic [31:0] held_data;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end else begin
         n_pass++;
      end
   endtask

   task automatic enqueueJob(input logic [31:0] base, input int cnt);
      logic [31:0] w;
      tok_base.push_back(base);
      tok_cnt.push_back(16'(cnt));
      for (int i = 0; i < cnt; i++) begin
         w = $urandom();
         data_q.push_back(w);
         exp_data.push_back(w);
         exp_addr.push_back(32'(base + 32'(i) * 32'd4));
      end
   endtask

   task automatic flushModel();
      tok_base.delete();
      tok_cnt.delete();
      data_q.delete();
      exp_addr.delete();
      exp_data.delete();
      pend_done.delete();
      cum_target   = accepted_total;
      hold_pending = 1'b0;
   endtask

   // One clock of stimulus plus all per-cycle observations against the model.
   task automatic applyStimulus();
      @(negedge clk);
      cyc++;
      start_empty_n = (tok_base.size() > 0);
      cfg_base_addr = '0;
      cfg_count     = '0;
      if (start_empty_n) begin
         cfg_base_addr = tok_base[0];
         cfg_count     = tok_cnt[0];
      end
      din_empty_n = (data_q.size() > 0) && (int'($urandom_range(99)) >= din_gap_pct);
      din_dout    = (data_q.size() > 0) ? data_q[0] : $urandom();
      if (stall_left > 0 && bus.wr_valid) begin
         bus.wr_ready = 1'b0;
         stall_left--;
      end else begin
         bus.wr_ready = (int'($urandom_range(99)) < ready_pct);
      end
      #1;

      if (hold_pending) begin
         checkOutput("hold_valid", bus.wr_valid, 1);
         checkOutput("hold_addr", bus.wr_addr, held_addr);
         checkOutput("hold_data", bus.wr_data, held_data);
      end
      hold_pending = bus.wr_valid && !bus.wr_ready;
      held_addr    = bus.wr_addr;
      held_data    = bus.wr_data;
      if (bus.wr_valid) valid_cycles++;
      if (bus.wr_valid && !bus.wr_ready) checkOutput("stall_din_read", din_read, 0);

      if (bus.wr_valid && bus.wr_ready) begin
         if (exp_addr.size() == 0) begin
            checkOutput("extra_beat", 1, 0);
         end else begin
            checkOutput("wr_addr", bus.wr_addr, exp_addr.pop_front());
            checkOutput("wr_data", bus.wr_data, exp_data.pop_front());
         end
         accepted_total++;
         job_beats++;
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
         last_beat_cyc = cyc;
      end

      if (din_read) begin
         din_reads++;
         if (!din_empty_n) checkOutput("din_read_empty", din_read, 0);
         else data_q.delete(0);
      end

      if (start_read) begin
         pops++;
         if (!start_empty_n) begin
            checkOutput("start_read_empty", start_read, 0);
         end else begin
            checkOutput("pop_overlap", pend_done.size(), 0);
            pop_gap        = cyc - done_cyc;
            pop_cyc        = cyc;
            first_beat_cyc = -1;
            job_beats      = 0;
            cum_target    += int'(tok_cnt[0]);
            pend_done.push_back(cum_target);
            tok_base.delete(0);
            tok_cnt.delete(0);
         end
      end

      if (done) begin
         done_count++;
         if (pend_done.size() == 0) checkOutput("spurious_done", done, 0);
         else checkOutput("done_beats", accepted_total, pend_done.pop_front());
         done_cyc = cyc;
      end
   endtask

   task automatic runJobs(input int bound);
      int  n = 0;
      bit  finished;
      do begin
         applyStimulus();
         n++;
         finished = (tok_base.size() == 0) && (pend_done.size() == 0) && idle;
      end while (!finished && n < bound);
      if (!finished) checkOutput("run_timeout", finished, 1);
   endtask

   int snap_din;
   int snap_valid;
   int snap_pops;
   int snap_done;

   initial begin
      reset_n       = 1'b0;
      bus.wr_ready  = 1'b1;
      start_empty_n = 1'b0;
      din_empty_n   = 1'b0;
      cfg_base_addr = '0;
      cfg_count     = '0;
      din_dout      = '0;

      // Reset state, with a token already waiting
      enqueueJob(32'h0000_1000, 4);
      repeat (2) applyStimulus();
      checkOutput("rst_idle", idle, 1);
      checkOutput("rst_wr_valid", bus.wr_valid, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_start_read", start_read, 0);
      checkOutput("rst_din_read", din_read, 0);
      checkOutput("rst_wr_addr", bus.wr_addr, 0);
      checkOutput("rst_wr_data", bus.wr_data, 0);
      reset_n = 1'b1;

      // Full FIFO, sink always ready: four back-to-back beats
      runJobs(60);
      checkOutput("t1_first_valid_lat", 32'(first_beat_cyc - pop_cyc), 2);
      checkOutput("t1_beat_span", 32'(last_beat_cyc - first_beat_cyc), 3);
      checkOutput("t1_done_lat", 32'(done_cyc - pop_cyc), 6);

      // Zero-length job
      snap_din = din_reads; snap_valid = valid_cycles; snap_pops = pops;
      enqueueJob(32'h0000_4000, 0);
      runJobs(30);
      checkOutput("t2_pops", 32'(pops - snap_pops), 1);
      checkOutput("t2_done_lat", 32'(done_cyc - pop_cyc), 1);
      checkOutput("t2_no_din_read", 32'(din_reads - snap_din), 0);
      checkOutput("t2_no_wr_valid", 32'(valid_cycles - snap_valid), 0);

      // Sink stalls for five cycles on the first beat
      stall_left = 5;
      enqueueJob(32'h0000_8000, 3);
      runJobs(60);
      checkOutput("t3_done_lat", 32'(done_cyc - pop_cyc), 10);

      // Address wrap at the top of the address space
      enqueueJob(32'hFFFF_FFF8, 3);
      runJobs(60);
      checkOutput("t4_done_lat", 32'(done_cyc - pop_cyc), 5);

      // Two queued tokens: second pop one cycle after done
      enqueueJob(32'h0000_A000, 2);
      enqueueJob(32'h0000_B000, 2);
      runJobs(60);
      checkOutput("t5_pop_gap", 32'(pop_gap), 1);

      // Reset in the middle of an eight-beat job
      job_beats = 0;
      enqueueJob(32'h0000_C000, 8);
      for (int n = 0; n < 40 && job_beats < 2; n++) applyStimulus();
      checkOutput("t6_reached_beat2", 32'(job_beats), 2);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t6_wr_valid", bus.wr_valid, 0);
      checkOutput("t6_idle", idle, 1);
      checkOutput("t6_done", done, 0);
      checkOutput("t6_wr_addr", bus.wr_addr, 0);
      checkOutput("t6_wr_data", bus.wr_data, 0);
      checkOutput("t6_din_read", din_read, 0);
      flushModel();
      snap_done = done_count;
      repeat (3) applyStimulus();
      reset_n = 1'b1;
      repeat (3) applyStimulus();
      checkOutput("t6_no_done", 32'(done_count - snap_done), 0);
      checkOutput("t6_idle_after", idle, 1);

      // Randomized jobs with sink back-pressure and data FIFO gaps
      ready_pct   = 70;
      din_gap_pct = 30;
      for (int j = 0; j < 20; j++) begin
         enqueueJob($urandom(), int'($urandom_range(0, 6)));
      end
      runJobs(3000);
      checkOutput("rand_all_beats", exp_addr.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kernel_cc_write_back_ctrl.md
KERNEL_CC_WRITE_BACK_CTRL -- requirements
Module: kernel_cc_write_back_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the write-back data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, beat-count width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_empty_n, input, 1, start-token FIFO holds a token.
REQ-007 SHALL have port start_read, output, 1, pop one start token.
REQ-008 SHALL have port cfg_base_addr, input, ADDR_WIDTH, first byte address, sampled on the start pop.
REQ-009 SHALL have port cfg_count, input, CNT_WIDTH, beats to write, sampled on the start pop.
REQ-010 SHALL have port din_empty_n, input, 1, data FIFO non-empty.
REQ-011 SHALL have port din_read, output, 1, pop one data word.
REQ-012 SHALL have port din_dout, input, DATA_WIDTH, data FIFO head word.
REQ-013 SHALL have port wr_valid, output, 1, write request valid.
REQ-014 SHALL have port wr_ready, input, 1, write sink accepts.
REQ-015 SHALL have port wr_addr, output, ADDR_WIDTH, request byte address.
REQ-016 SHALL have port wr_data, output, DATA_WIDTH, request data.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at job end.
REQ-018 SHALL have port idle, output, 1, high in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE.
REQ-020 In IDLE, start_read SHALL equal start_empty_n combinationally; on a pop, it SHALL latch cfg_base_addr/cfg_count and go to RUN, or go to DONE if cfg_count==0.
REQ-021 start_read SHALL be 0 outside IDLE; at most one token SHALL be popped per job.
REQ-022 In RUN, din_read SHALL be din_empty_n & (issued<count) & (!wr_valid | wr_ready).
REQ-023 wr_valid/wr_data/wr_addr SHALL be registered, loaded the cycle after din_read, and held stable while wr_valid & !wr_ready.
REQ-024 Throughput SHALL be one beat per cycle with wr_ready held high; there SHALL be no bubble between beats.
REQ-025 wr_addr SHALL start at base and increase by DATA_WIDTH/8 per accepted beat, wrapping modulo 2^ADDR_WIDTH.
REQ-026 The issued and accepted counters SHALL be CNT_WIDTH wide; cfg_count=2^CNT_WIDTH-1 SHALL be supported without overflow.
REQ-027 The last wr_valid&wr_ready handshake SHALL move RUN to DONE on the same edge.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; a new token SHALL be popped no earlier than the cycle after DONE.
REQ-029 Latency: pop at cycle T, first din_read at T+1 earliest, first wr_valid at T+2.
REQ-030 An empty data FIFO SHALL stall without losing or duplicating words; wr_ready low SHALL stall din_read when the output register is full.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, clear the counters and set wr_valid=0, done=0, start_read=0, din_read=0, wr_addr=0, wr_data=0, idle=1.
REQ-032 Reset mid-job SHALL abandon the job; the in-flight request SHALL be dropped and no done SHALL be produced.
REQ-033 Reset release SHALL take effect synchronously on the next clk edge.

Structure
REQ-034 The FSM state encoding and the BYTES_PER_BEAT=DATA_WIDTH/8 constant SHALL live in the shared package kernel_cc_pkg.
REQ-035 One sub-module SHALL be used: kernel_cc_write_back_ctrl_outreg, the valid/ready output register holding wr_valid, wr_addr and wr_data.

Verification
REQ-036 Bench SHALL cover: base=0x1000, count=4, FIFO full, wr_ready=1 -> addrs 0x1000/04/08/0C on 4 consecutive cycles, done at T+6.
REQ-037 Bench SHALL cover: count=0 -> start_read pulse, done the next cycle, no wr_valid, no din_read.
REQ-038 Bench SHALL cover: count=3, wr_ready low for 5 cycles on beat 1 -> wr_addr/wr_data held stable, din_read=0 while stalled, all 3 beats in order.
REQ-039 Bench SHALL cover: base=0xFFFFFFF8, count=3 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-040 Bench SHALL cover: two queued tokens -> second pop exactly one cycle after done, no overlap.
REQ-041 Bench SHALL cover: reset_n low after beat 2 of count=8 -> outputs at reset values immediately, no done, idle=1.
